rank_filter_3x3: RTL and testbench
==================================

# rank_filter_3x3

Streaming 3×3 rank-order filter for the image pipeline, the parametrised successor of the fixed 5-bit median stage. It accepts one 3-pixel column per valid cycle and maintains a sliding 3×3 window. For every full window it outputs the median, minimum, maximum or centre pixel, selected per window. It adds valid/last framing, per-line window priming and a two-stage pipelined sorting network, and sits between the line-buffer reader and the downstream edge/threshold stages.

## Interface
- PIX_W, 5: pixel width in bits (2..16)
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  column present this cycle
- in_last  in  1  qualifies in_valid; marks the last column of a line
- col_in  in  3*PIX_W  column; bits [PIX_W-1:0] = row 0, then row 1, then row 2
- mode  in  2  0 median, 1 min, 2 max, 3 centre pass-through; sampled with the column
- out_valid  out  1  pixel_out holds a result
- pixel_out  out  PIX_W  filtered pixel
- done  out  1  one-cycle pulse when the line's last column has left the pipeline
- busy  out  1  high while any window column or pipeline stage holds live data

## Operation
- Window columns c0 (oldest), c1, c2. Pixel index: x0–x2 = c0 rows 0–2, x3–x5 = c1, x6–x8 = c2; centre = x4.
- Accepted column (in_valid=1): c0←c1, c1←c2, c2←col_in. No shift when in_valid=0.
- FSM on window fill:
  - IDLE: no valid columns held.
  - FILL: 1–2 valid columns held.
  - RUN: 3 or more valid columns held.
  - Transitions: IDLE→FILL on accept; FILL→RUN on accept of the 3rd column; any state→IDLE on accept with in_last=1, after that column is shifted in.
- A window is valid when the accepting cycle leaves or keeps the FSM at 3+ columns, including the in_last column itself.
- in_last on the 1st or 2nd column of a line: no result is produced. done still pulses.
- Next line always re-primes; no output mixes columns from two lines.
- Each pipeline stage carries valid, last and mode bits. Pipeline advances every cycle with no backpressure. Gaps become bubbles with out_valid=0.
- Mode changes take effect on the window whose final column is accepted with the new mode.
- Arithmetic is unsigned compare only, with no width growth. Ties are resolved arbitrarily; any equal value is correct.
- in_last with in_valid=0 is ignored.

## Timing
- Column presented in cycle n → result on pixel_out/out_valid in cycle n+3. The three register stages are the window, the sort stage 1 register and the output register.
- done = 1 in cycle n+3 for the in_last column, for exactly one cycle, regardless of out_valid.
- pixel_out holds its last value when out_valid=0.
- busy = 1 from the cycle after the first accept until the cycle after done. It stays high in FILL/RUN with no input.
- Reset: out_valid=0, pixel_out=0, done=0, busy=0, FSM=IDLE, all window and pipeline registers 0.
- Reset mid-stream discards all in-flight windows. No done pulse follows. The first column after reset release is treated as column 1.
- Throughput: one result per cycle in RUN with continuous in_valid.

## Structure
- Package rank_filter_pkg holds:
  - mode encodings MODE_MEDIAN/MODE_MIN/MODE_MAX/MODE_CENTRE
  - FSM state encodings IDLE/FILL/RUN
  - default PIX_W
- Sub-module rank_filter_sort3: sorts three PIX_W values into max/mid/min.
  - Stage 1 sorts the three columns with three instances and registers the results.
  - Stage 2 forms the median as med3(min of maxes, med of mids, max of mins). The global min and max come from the stage-1 extrema; the centre is carried through.
  - Stage 2 muxes the result by mode.

## Test plan
- Hold reset, toggle inputs → all outputs 0. Release; no out_valid without input.
- PIX_W=5, mode 0: columns (9,1,8), (2,30,3), (7,4,6) on consecutive cycles, 3rd column in cycle n → out_valid and pixel_out=6 in cycle n+3 only.
- Same window with mode 1/2/3 → 1, 30, 30 respectively. Change mode to 1 on a following 4th column (5,5,5) → window (2,30,3)(7,4,6)(5,5,5) yields 2.
- Same three columns with one idle cycle between each → exactly one out_valid, 3 cycles after the last accept; intermediate cycles have out_valid=0.
- in_last on the 2nd column → no out_valid, done pulses 3 cycles later. The next 3 columns produce a result only after the 3rd.
- Reset asserted one cycle after the 3rd column → no out_valid or done. After release, two columns → no output.

Source files
------------

// File: rtl/rank_filter_pkg.sv
// rank_filter_pkg: shared encodings and defaults for the 3x3 rank filter
package rank_filter_pkg;
  localparam int PIX_W_DEF = 5;
  typedef enum logic [1:0] {MODE_MEDIAN, MODE_MIN, MODE_MAX, MODE_CENTRE} mode_e;
  typedef enum logic [1:0] {IDLE, FILL, RUN} state_e;
endpackage

// File: rtl/rank_filter_sort3.sv
// rank_filter_sort3: orders three unsigned values into hi/md/lo
module rank_filter_sort3 #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] hi,
  output logic [W-1:0] md,
  output logic [W-1:0] lo
);
  logic [W-1:0] ab_hi, ab_lo;
  // order the first pair, then place the third value around it
  always_comb begin
    ab_hi = a > b ? a : b;
    ab_lo = a > b ? b : a;
    hi = ab_hi > c ? ab_hi : c;
    lo = ab_lo < c ? ab_lo : c;
    md = c > ab_hi ? ab_hi : c < ab_lo ? ab_lo : c;
  end
endmodule

// File: rtl/rank_filter_3x3.sv
// rank_filter_3x3: streaming 3x3 median/min/max/centre filter with line framing
module rank_filter_3x3
  import rank_filter_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               in_last,
  input  logic [3*PIX_W-1:0] col_in,
  input  logic [1:0]         mode,
  output logic               out_valid,
  output logic [PIX_W-1:0]   pixel_out,
  output logic               done,
  output logic               busy
);
  state_e             state;
  logic               two;
  logic [3*PIX_W-1:0] win [3];
  logic               win_v, win_last;
  mode_e              win_mode;
  logic [PIX_W-1:0]   hi [3], md [3], lo [3];
  logic [PIX_W-1:0]   s1_hi [3], s1_md [3], s1_lo [3];
  logic [PIX_W-1:0]   s1_ctr, med, res;
  logic               s1_v, s1_last;
  mode_e              s1_mode;

  function automatic logic [PIX_W-1:0] mx(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
    return a > b ? a : b;
  endfunction

  function automatic logic [PIX_W-1:0] mn(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
    return a > b ? b : a;
  endfunction

  function automatic logic [PIX_W-1:0] med3(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b, input logic [PIX_W-1:0] c);
    return mx(mn(a, b), mn(mx(a, b), c));
  endfunction

  // window shift and fill tracking; a window is valid once three columns of the current line are held
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      two <= 1'b0;
      win <= '{default: '0};
      win_v <= 1'b0;
      win_last <= 1'b0;
      win_mode <= MODE_MEDIAN;
    end else begin
      win_v <= in_valid && (state == RUN || (state == FILL && two));
      win_last <= in_valid && in_last;
      if (in_valid) begin
        win <= '{win[1], win[2], col_in};
        win_mode <= mode_e'(mode);
        two <= state == FILL;
        state <= in_last ? IDLE : state == IDLE ? FILL : (state == FILL && !two) ? FILL : RUN;
      end
    end

  for (genvar i = 0; i < 3; i++) begin : g_col
    rank_filter_sort3 #(.W(PIX_W)) u_sort (
      .a (win[i][PIX_W-1:0]),
      .b (win[i][2*PIX_W-1:PIX_W]),
      .c (win[i][3*PIX_W-1:2*PIX_W]),
      .hi(hi[i]),
      .md(md[i]),
      .lo(lo[i])
    );
  end

  // register the per-column sort along with the centre pixel and framing
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s1_hi <= '{default: '0};
      s1_md <= '{default: '0};
      s1_lo <= '{default: '0};
      s1_ctr <= '0;
      s1_v <= 1'b0;
      s1_last <= 1'b0;
      s1_mode <= MODE_MEDIAN;
    end else begin
      s1_hi <= hi;
      s1_md <= md;
      s1_lo <= lo;
      s1_ctr <= win[1][2*PIX_W-1:PIX_W];
      s1_v <= win_v;
      s1_last <= win_last;
      s1_mode <= win_mode;
    end

  assign med = med3(mn(mn(s1_hi[0], s1_hi[1]), s1_hi[2]), med3(s1_md[0], s1_md[1], s1_md[2]),
                    mx(mx(s1_lo[0], s1_lo[1]), s1_lo[2]));

  // pick the requested rank statistic
  always_comb
    res = s1_mode == MODE_MEDIAN ? med :
          s1_mode == MODE_MIN    ? mn(mn(s1_lo[0], s1_lo[1]), s1_lo[2]) :
          s1_mode == MODE_MAX    ? mx(mx(s1_hi[0], s1_hi[1]), s1_hi[2]) : s1_ctr;

  // output register; the pixel holds between results
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      out_valid <= 1'b0;
      pixel_out <= '0;
      done <= 1'b0;
    end else begin
      out_valid <= s1_v;
      done <= s1_last;
      if (s1_v) pixel_out <= res;
    end

  assign busy = state != IDLE || win_v || win_last || s1_v || s1_last || done;
endmodule

// File: tb/tb_rank_filter_3x3.sv
// tb_rank_filter_3x3: directed and random checks against a sorting reference model
module tb_rank_filter_3x3;
  localparam int P = 5;
  localparam logic [3*P-1:0] COL_A = {5'd8, 5'd1, 5'd9};
  localparam logic [3*P-1:0] COL_B = {5'd3, 5'd30, 5'd2};
  localparam logic [3*P-1:0] COL_C = {5'd6, 5'd4, 5'd7};
  localparam logic [3*P-1:0] COL_D = {5'd5, 5'd5, 5'd5};

  typedef struct {
    logic v;
    logic d;
    int   p;
  } ent_t;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_last = 1'b0;
  logic [3*P-1:0] col_in = '0;
  logic [1:0]     mode = '0;
  logic           out_valid, done, busy;
  logic [P-1:0]   pixel_out;

  int             checks = 0;
  int             errors = 0;
  ent_t           q[$];
  logic [3*P-1:0] line[$];
  int             hold;

  rank_filter_3x3 #(.PIX_W(P)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_last  (in_last),
    .col_in   (col_in),
    .mode     (mode),
    .out_valid(out_valid),
    .pixel_out(pixel_out),
    .done     (done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ent_t z;
    z.v = 1'b0;
    z.d = 1'b0;
    z.p = 0;
    q = {};
    q.push_back(z);
    q.push_back(z);
    line = {};
    hold = 0;
  endtask

  task automatic cyc(input logic v, input logic l, input logic [3*P-1:0] c, input logic [1:0] m);
    ent_t e, front;
    int   px[$];
    int   ctr;
    logic eb;
    in_valid = v;
    in_last = l;
    col_in = c;
    mode = m;
    @(posedge clk);
    #1;
    e.v = 1'b0;
    e.d = 1'b0;
    e.p = 0;
    if (v) begin
      line.push_back(c);
      if (line.size() > 3) void'(line.pop_front());
      if (line.size() == 3) begin
        px = {};
        foreach (line[k]) for (int r = 0; r < 3; r++) px.push_back(int'(line[k][r*P +: P]));
        ctr = px[4];
        px.sort();
        e.v = 1'b1;
        e.p = m == 2'd0 ? px[4] : m == 2'd1 ? px[0] : m == 2'd2 ? px[8] : ctr;
      end
      e.d = l;
      if (l) line = {};
    end
    q.push_back(e);
    eb = line.size() > 0;
    foreach (q[k]) eb |= q[k].v | q[k].d;
    front = q.pop_front();
    if (front.v) hold = front.p;
    chk("out_valid", 32'(out_valid), 32'(front.v));
    chk("done", 32'(done), 32'(front.d));
    chk("pixel_out", 32'(pixel_out), 32'(hold));
    chk("busy", 32'(busy), 32'(eb));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 15'(i * 7), 2'(i));
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      in_valid = i[0];
      in_last = i[1];
      col_in = 15'($urandom);
      mode = 2'(i);
      @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_pixel", 32'(pixel_out), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end
    reset = 1'b0;
    model_reset();
    idle(3);

    cyc(1'b1, 1'b0, COL_A, 2'd0);
    cyc(1'b1, 1'b0, COL_B, 2'd0);
    cyc(1'b1, 1'b0, COL_C, 2'd0);
    cyc(1'b1, 1'b1, COL_D, 2'd1);
    idle(1);
    chk("median_valid", 32'(out_valid), 32'd1);
    chk("median_val", 32'(pixel_out), 32'd6);
    idle(1);
    chk("modechg_val", 32'(pixel_out), 32'd2);
    chk("modechg_done", 32'(done), 32'd1);
    idle(2);
    chk("line_end_busy", 32'(busy), 32'd0);

    for (int m = 1; m < 4; m++) begin
      cyc(1'b1, 1'b0, COL_A, 2'(m));
      cyc(1'b1, 1'b0, COL_B, 2'(m));
      cyc(1'b1, 1'b1, COL_C, 2'(m));
      idle(2);
      chk("mode_valid", 32'(out_valid), 32'd1);
      chk("mode_val", 32'(pixel_out), m == 1 ? 32'd1 : 32'd30);
      chk("mode_done", 32'(done), 32'd1);
    end

    cyc(1'b1, 1'b0, COL_A, 2'd0);
    idle(1);
    cyc(1'b1, 1'b0, COL_B, 2'd0);
    idle(1);
    cyc(1'b1, 1'b1, COL_C, 2'd0);
    idle(2);
    chk("gap_valid", 32'(out_valid), 32'd1);
    chk("gap_val", 32'(pixel_out), 32'd6);
    idle(1);

    cyc(1'b1, 1'b0, COL_A, 2'd0);
    cyc(1'b1, 1'b1, COL_B, 2'd0);
    idle(2);
    chk("short_done", 32'(done), 32'd1);
    chk("short_valid", 32'(out_valid), 32'd0);
    cyc(1'b1, 1'b0, COL_C, 2'd2);
    cyc(1'b1, 1'b0, COL_A, 2'd2);
    cyc(1'b1, 1'b1, COL_B, 2'd2);
    idle(2);
    chk("reprime_val", 32'(pixel_out), 32'd30);

    cyc(1'b1, 1'b0, COL_A, 2'd0);
    cyc(1'b1, 1'b0, COL_B, 2'd0);
    cyc(1'b1, 1'b1, COL_C, 2'd0);
    idle(1);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("midrst_valid", 32'(out_valid), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
    end
    reset = 1'b0;
    model_reset();
    cyc(1'b1, 1'b0, COL_A, 2'd0);
    cyc(1'b1, 1'b0, COL_B, 2'd0);
    idle(4);
    chk("post_rst_valid", 32'(out_valid), 32'd0);

    for (int i = 0; i < 400; i++) begin
      logic v, l;
      v = $urandom_range(0, 3) != 0;
      l = v && $urandom_range(0, 9) == 0;
      cyc(v, l, 15'($urandom), 2'($urandom_range(0, 3)));
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
